// File: rtl/conf_regs_serializer_pkg.sv
// Shared defaults, FSM state type and sizing helper for the configuration register serializer.
package conf_regs_serializer_pkg;

  localparam int unsigned NUM_REGS_DEF   = 4;
  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned TX_WIDTH_DEF   = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_CSUM
  } state_t;

  // Chunk counter width; a single chunk per register still needs one bit.
  function automatic int unsigned chunk_bits(input int unsigned num_chunks);
    return (num_chunks > 1) ? $clog2(num_chunks) : 1;
  endfunction

endpackage

// File: rtl/conf_regs_serializer_word_select.sv
// conf_word_select: combinational pick of one TX_WIDTH chunk of one snapshot register.
module conf_word_select
  import conf_regs_serializer_pkg::*;
#(
  parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned TX_WIDTH   = TX_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned CHUNK_W    = chunk_bits(DATA_WIDTH / TX_WIDTH)
) (
  input  logic [DATA_WIDTH*NUM_REGS-1:0] snapshot,
  input  logic [ADDR_WIDTH-1:0]          index,
  input  logic [CHUNK_W-1:0]             chunk,
  output logic [TX_WIDTH-1:0]            word
);

  localparam int unsigned NUM_CHUNKS = DATA_WIDTH / TX_WIDTH;

  // Explicit decode keeps out-of-range indices from producing out-of-bounds selects.
  always_comb begin
    word = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      for (int unsigned c = 0; c < NUM_CHUNKS; c++) begin
        if (index == ADDR_WIDTH'(r) && chunk == CHUNK_W'(c))
          word = snapshot[r*DATA_WIDTH + c*TX_WIDTH +: TX_WIDTH];
      end
    end
  end

endmodule

// File: rtl/conf_regs_serializer.sv
// Snapshots the register array and streams a register range as TX_WIDTH words over valid/ack.
// Optional trailing XOR checksum word when CONF_SER_CHECKSUM_EN is defined.
module conf_regs_serializer
  import conf_regs_serializer_pkg::*;
#(
  parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned TX_WIDTH   = TX_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH*NUM_REGS-1:0] registers,
  input  logic                           request,
  input  logic [ADDR_WIDTH-1:0]          first_reg,
  input  logic [ADDR_WIDTH-1:0]          last_reg,
  input  logic                           ack,
  output logic [TX_WIDTH-1:0]            tx_data,
  output logic                           tx_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           error
);

  localparam int unsigned         NUM_CHUNKS = DATA_WIDTH / TX_WIDTH;
  localparam int unsigned         CHUNK_W    = chunk_bits(NUM_CHUNKS);
  localparam logic [CHUNK_W-1:0]  LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);
  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

  state_t                         state;
  logic [DATA_WIDTH*NUM_REGS-1:0] snapshot;
  logic [ADDR_WIDTH-1:0]          index;
  logic [ADDR_WIDTH-1:0]          last_idx;
  logic [CHUNK_W-1:0]             chunk;
  logic [TX_WIDTH-1:0]            word;
  logic                           range_ok;

  conf_word_select #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .TX_WIDTH   (TX_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CHUNK_W    (CHUNK_W)
  ) u_word_select (
    .snapshot (snapshot),
    .index    (index),
    .chunk    (chunk),
    .word     (word)
  );

  always_comb begin
    range_ok = (first_reg <= last_reg) && ({1'b0, last_reg} < NUM_REGS_W);
  end

`ifdef CONF_SER_CHECKSUM_EN
  logic [TX_WIDTH-1:0] csum;
  logic                show_csum;

  always_comb begin
    tx_data = show_csum ? csum : word;
  end
`else
  always_comb begin
    tx_data = word;
  end
`endif

  // Counters stop at their terminal values, so the last word stays on tx_data after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      snapshot <= '0;
      index    <= '0;
      last_idx <= '0;
      chunk    <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef CONF_SER_CHECKSUM_EN
      csum      <= '0;
      show_csum <= 1'b0;
`endif
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (request) begin
            if (range_ok) begin
              snapshot <= registers;
              index    <= first_reg;
              last_idx <= last_reg;
              chunk    <= '0;
              tx_valid <= 1'b1;
              busy     <= 1'b1;
              state    <= ST_SEND;
`ifdef CONF_SER_CHECKSUM_EN
              csum      <= '0;
              show_csum <= 1'b0;
`endif
            end else begin
              error <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (ack) begin
`ifdef CONF_SER_CHECKSUM_EN
            csum <= csum ^ word;
`endif
            if (chunk == LAST_CHUNK) begin
              if (index == last_idx) begin
`ifdef CONF_SER_CHECKSUM_EN
                show_csum <= 1'b1;
                state     <= ST_CSUM;
`else
                tx_valid <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
                state    <= ST_IDLE;
`endif
              end else begin
                index <= index + 1'b1;
                chunk <= '0;
              end
            end else begin
              chunk <= chunk + 1'b1;
            end
          end
        end
`ifdef CONF_SER_CHECKSUM_EN
        ST_CSUM: begin
          if (ack) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conf_regs_serializer.sv
// Directed self-checking bench for conf_regs_serializer (4 x 16-bit registers, 8-bit words).
module tb_conf_regs_serializer;

  localparam logic [63:0] REG_INIT = 64'h0718_E5F6_C3D4_A1B2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] registers;
  logic        request;
  logic [2:0]  first_reg;
  logic [2:0]  last_reg;
  logic        ack;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;
  logic        error;

  int unsigned checks = 0;
  int unsigned errors = 0;

  conf_regs_serializer #(
    .NUM_REGS   (4),
    .DATA_WIDTH (16),
    .TX_WIDTH   (8),
    .ADDR_WIDTH (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .registers (registers),
    .request   (request),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .ack       (ack),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word currently presented, transfer still running.
  task automatic expect_word(input string tag, input logic [7:0] w);
    chk({tag, " data"},  16'(tx_data),  16'(w));
    chk({tag, " valid"}, 16'(tx_valid), 16'd1);
    chk({tag, " busy"},  16'(busy),     16'd1);
    chk({tag, " done"},  16'(done),     16'd0);
  endtask

  // Cycle right after the final ack.
  task automatic expect_done(input string tag, input logic [7:0] held);
    chk({tag, " done"},  16'(done),     16'd1);
    chk({tag, " valid"}, 16'(tx_valid), 16'd0);
    chk({tag, " busy"},  16'(busy),     16'd0);
    chk({tag, " held"},  16'(tx_data),  16'(held));
  endtask

  task automatic expect_all_zero(input string tag);
    chk({tag, " data"},  16'(tx_data),  16'd0);
    chk({tag, " valid"}, 16'(tx_valid), 16'd0);
    chk({tag, " busy"},  16'(busy),     16'd0);
    chk({tag, " done"},  16'(done),     16'd0);
    chk({tag, " error"}, 16'(error),    16'd0);
  endtask

  logic [7:0] full_words [8];
  logic [7:0] mid_words  [4];
  logic [7:0] last_word;

  initial begin
    full_words = '{8'hB2, 8'hA1, 8'hD4, 8'hC3, 8'hF6, 8'hE5, 8'h18, 8'h07};
    mid_words  = '{8'hD4, 8'hC3, 8'hF6, 8'hE5};

    rst = 1'b1; registers = REG_INIT; request = 1'b0;
    first_reg = '0; last_reg = '0; ack = 1'b0;
    step(); step();
    expect_all_zero("reset");
    rst = 1'b0;
    step();
    expect_all_zero("idle");

    // Full range, ack held high from the request cycle on.
    request = 1'b1; first_reg = 3'd0; last_reg = 3'd3; ack = 1'b1;
    step();
    request = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_word($sformatf("full w%0d", i), full_words[i]);
      step();
    end
    last_word = 8'h07;
`ifdef CONF_SER_CHECKSUM_EN
    expect_word("full csum", 8'h08);
    step();
    last_word = 8'h08;
`endif
    expect_done("full end", last_word);
    ack = 1'b0;
    step();
    chk("full done once", 16'(done), 16'd0);

    // Range 1..2, ack every third cycle.
    request = 1'b1; first_reg = 3'd1; last_reg = 3'd2;
    step();
    request = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_word($sformatf("mid w%0d a", i), mid_words[i]);
      step();
      expect_word($sformatf("mid w%0d b", i), mid_words[i]);
      step();
      expect_word($sformatf("mid w%0d c", i), mid_words[i]);
      ack = 1'b1;
      step();
      ack = 1'b0;
    end
    last_word = 8'hE5;
`ifdef CONF_SER_CHECKSUM_EN
    expect_word("mid csum a", 8'h04);
    step();
    expect_word("mid csum b", 8'h04);
    ack = 1'b1;
    step();
    ack = 1'b0;
    last_word = 8'h04;
`endif
    expect_done("mid end", last_word);
    step();

    // Invalid ranges: reversed, then past the last register.
    request = 1'b1; first_reg = 3'd2; last_reg = 3'd1;
    step();
    request = 1'b0;
    chk("rev error",  16'(error),    16'd1);
    chk("rev busy",   16'(busy),     16'd0);
    chk("rev valid",  16'(tx_valid), 16'd0);
    step();
    chk("rev error pulse", 16'(error), 16'd0);
    request = 1'b1; first_reg = 3'd0; last_reg = 3'd4;
    step();
    request = 1'b0;
    chk("oob error",  16'(error),    16'd1);
    chk("oob busy",   16'(busy),     16'd0);
    chk("oob valid",  16'(tx_valid), 16'd0);
    step();
    chk("oob error pulse", 16'(error), 16'd0);
    chk("oob still idle",  16'(busy),  16'd0);

    // Snapshot isolation and request-while-busy.
    request = 1'b1; first_reg = 3'd0; last_reg = 3'd3; ack = 1'b1;
    step();
    request = 1'b0;
    expect_word("snap w0", 8'hB2);
    step();
    expect_word("snap w1", 8'hA1);
    step();
    registers = '0;
    request = 1'b1; first_reg = 3'd0; last_reg = 3'd0;
    for (int i = 2; i < 8; i++) begin
      expect_word($sformatf("snap w%0d", i), full_words[i]);
      step();
      request = 1'b0;
    end
    last_word = 8'h07;
`ifdef CONF_SER_CHECKSUM_EN
    expect_word("snap csum", 8'h08);
    step();
    last_word = 8'h08;
`endif
    expect_done("snap end", last_word);
    ack = 1'b0;
    registers = REG_INIT;
    step();

    // Reset mid-transfer after the third word has been accepted.
    request = 1'b1; first_reg = 3'd0; last_reg = 3'd3; ack = 1'b1;
    step();
    request = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_word($sformatf("abort w%0d", i), full_words[i]);
      step();
    end
    rst = 1'b1; ack = 1'b0;
    step();
    expect_all_zero("abort reset");
    rst = 1'b0;
    step();
    expect_all_zero("abort no done");

    // Range 3..3, then a new request during the done cycle.
    request = 1'b1; first_reg = 3'd3; last_reg = 3'd3; ack = 1'b1;
    step();
    request = 1'b0;
    expect_word("r3 w0", 8'h18);
    step();
    expect_word("r3 w1", 8'h07);
    step();
    last_word = 8'h07;
`ifdef CONF_SER_CHECKSUM_EN
    expect_word("r3 csum", 8'h1F);
    step();
    last_word = 8'h1F;
`endif
    expect_done("r3 end", last_word);
    request = 1'b1; first_reg = 3'd0; last_reg = 3'd0; ack = 1'b0;
    step();
    request = 1'b0;
    expect_word("b2b w0", 8'hB2);
    ack = 1'b1;
    step();
    expect_word("b2b w1", 8'hA1);
    step();
    last_word = 8'hA1;
`ifdef CONF_SER_CHECKSUM_EN
    expect_word("b2b csum", 8'h13);
    step();
    last_word = 8'h13;
`endif
    expect_done("b2b end", last_word);
    ack = 1'b0;
    step();
    chk("b2b done once", 16'(done), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
